// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package mdu_pkg;

    // Operation codes on the op input; 110/111 are no-ops.
    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } mduState_e;

    typedef enum logic {
        ModeMul,
        ModeDiv
    } iterMode_e;

    // Counter must hold 0..width, hence the +1.
    function automatic int unsigned cntWidth(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    function automatic logic isMulDiv(input logic [2:0] code);
        return !code[2];
    endfunction

    function automatic logic isMulOp(input logic [2:0] code);
        return code[2:1] == 2'b00;
    endfunction

    // MULT and DIV are the signed variants (even codes).
    function automatic logic isSignedOp(input logic [2:0] code);
        return !code[0];
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on
// unsigned magnitudes. The 2*WIDTH register holds {partial, multiplier} for
// multiply and {remainder, quotient} for divide.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 step,
    input  iterMode_e            mode,
    input  logic [WIDTH-1:0]     initLo,
    input  logic [WIDTH-1:0]     initOpnd,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] accReg;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     trial;

    // One iteration: conditional add then shift right, or trial subtract then shift left.
    always_comb begin
        addSum  = {1'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {1'b0, opnd} : '0);
        trial   = accReg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        accNext = accReg;
        if (mode == ModeMul) begin
            accNext = {addSum, accReg[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            accNext = {trial[WIDTH-1:0], accReg[WIDTH-2:0], 1'b1};
        end else begin
            accNext = {accReg[2*WIDTH-2:0], 1'b0};
        end
    end

    // Load operands on init, advance one bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            accReg <= '0;
            opnd   <= '0;
        end else if (init) begin
            accReg <= {{WIDTH{1'b0}}, initLo};
            opnd   <= initOpnd;
        end else if (step) begin
            accReg <= accNext;
        end
    end

    assign acc = accReg;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Owns the control FSM, iteration counter, sign bookkeeping and the final
// sign-fix stage; the bit-serial arithmetic lives in mdu_iter_core.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = cntWidth(WIDTH);

    mduState_e          state;
    logic [CntW-1:0]    cnt;
    logic               isDivOp;
    logic               negRes;
    logic               negRem;
    logic               divZero;
    logic [WIDTH-1:0]   aSaved;

    logic               opIsMulDiv;
    logic               opIsMul;
    logic               opSigned;
    logic               accept;
    logic               fastIssue;
    logic               coreInit;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] fastProd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;
    iterMode_e          coreMode;

    // Decode the incoming op and form operand magnitudes for the iterative core.
    always_comb begin
        opIsMulDiv = isMulDiv(op);
        opIsMul    = isMulOp(op);
        opSigned   = isSignedOp(op);
        accept     = start && !flush && (state == StIdle);
        fastIssue  = accept && opIsMul && FAST_MUL;
        coreInit   = accept && opIsMulDiv && !fastIssue;
        magA       = (opSigned && a[WIDTH-1]) ? -a : a;
        magB       = (opSigned && b[WIDTH-1]) ? -b : b;
        // Sign-extended operands give the signed product modulo 2^(2*WIDTH).
        fastProd   = {{WIDTH{opSigned & a[WIDTH-1]}}, a} * {{WIDTH{opSigned & b[WIDTH-1]}}, b};
        coreMode   = isDivOp ? ModeDiv : ModeMul;
    end

    assign busy      = (state != StIdle);
    assign stall_req = busy | (start & opIsMulDiv & ~flush);

    mdu_iter_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .init     (coreInit),
        .step     (state == StRun),
        .mode     (coreMode),
        .initLo   (opIsMul ? magB : magA),
        .initOpnd (opIsMul ? magA : magB),
        .acc      (acc)
    );

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        prodFix = negRes ? -acc : acc;
        quotFix = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remFix  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!isDivOp) begin
            fixHi = prodFix[2*WIDTH-1:WIDTH];
            fixLo = prodFix[WIDTH-1:0];
        end else if (divZero) begin
            fixHi = aSaved;
            fixLo = {WIDTH{1'b1}};
        end else begin
            fixHi = remFix;
            fixLo = quotFix;
        end
    end

    // Control FSM with registered HI/LO and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            isDivOp <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            aSaved  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start && !flush) begin
                        if (op == MDU_MTHI) begin
                            hi <= a;
                        end else if (op == MDU_MTLO) begin
                            lo <= a;
                        end else if (fastIssue) begin
                            hi   <= fastProd[2*WIDTH-1:WIDTH];
                            lo   <= fastProd[WIDTH-1:0];
                            done <= 1'b1;
                        end else if (opIsMulDiv) begin
                            state   <= StRun;
                            cnt     <= '0;
                            isDivOp <= op[1];
                            negRes  <= opSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                            negRem  <= opSigned & op[1] & a[WIDTH-1];
                            divZero <= op[1] & (b == '0);
                            aSaved  <= a;
                        end
                    end
                end
                StRun: begin
                    if (flush) begin
                        state <= StIdle;
                    end else if (cnt == CntW'(WIDTH - 1)) begin
                        state <= StFix;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StFix: begin
                    state <= StIdle;
                    if (!flush) begin
                        hi   <= fixHi;
                        lo   <= fixLo;
                        done <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
